// File: rtl/seq_divider4_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master requests a divide; the slave (divider) returns quotient, remainder and flags.
interface seq_divider4_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     y;
   logic [2*WIDTH-1:0]   quot;
   logic [WIDTH-1:0]     rem;
   logic                 busy;
   logic                 done;
   logic                 div_zero;

   modport master (
      output start, prod, y,
      input  quot, rem, busy, done, div_zero
   );

   modport slave (
      input  start, prod, y,
      output quot, rem, busy, done, div_zero
   );
endinterface

// File: rtl/seq_divider4.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
module seq_divider4 #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider4_if.slave bus
);
   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [DW-1:0]    dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH:0]   pr_r;
   logic [CW-1:0]    cnt_r;
   logic [DW-1:0]    quot_r;
   logic [WIDTH-1:0] rem_r;
   logic             busy_r;
   logic             done_r;
   logic             div_zero_r;

   logic [WIDTH+1:0] pr_shift_s;
   logic [WIDTH+1:0] diff_s;
   logic [WIDTH:0]   pr_next_s;
   logic             q_bit_s;
   logic [DW-1:0]    dvd_next_s;
   logic             last_s;

   // One restoring iteration; the freed dividend LSBs collect the quotient bits.
   always_comb begin
      pr_shift_s = {pr_r, dvd_r[DW-1]};
      diff_s     = pr_shift_s - {2'b00, dvs_r};
      pr_next_s  = pr_shift_s[WIDTH:0];
      q_bit_s    = 1'b0;
      if (diff_s[WIDTH+1] == 1'b0) begin
         pr_next_s = diff_s[WIDTH:0];
         q_bit_s   = 1'b1;
      end else begin
         pr_next_s = pr_shift_s[WIDTH:0];
         q_bit_s   = 1'b0;
      end
      dvd_next_s = {dvd_r[DW-2:0], q_bit_s};
      last_s     = (cnt_r == CW'(DW - 1));
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         dvd_r      <= '0;
         dvs_r      <= '0;
         pr_r       <= '0;
         cnt_r      <= '0;
         quot_r     <= '0;
         rem_r      <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  busy_r <= 1'b1;
                  if (bus.y != '0) begin
                     dvd_r   <= bus.prod;
                     dvs_r   <= bus.y;
                     pr_r    <= '0;
                     cnt_r   <= '0;
                     state_r <= CALC;
                  end else begin
                     // Zero divisor short-circuits straight to the result
                     quot_r     <= '1;
                     rem_r      <= '0;
                     div_zero_r <= 1'b1;
                     done_r     <= 1'b1;
                     state_r    <= DONE;
                  end
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            CALC: begin
               pr_r  <= pr_next_s;
               dvd_r <= dvd_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (last_s) begin
                  quot_r     <= dvd_next_s;
                  rem_r      <= pr_next_s[WIDTH-1:0];
                  div_zero_r <= 1'b0;
                  done_r     <= 1'b1;
                  state_r    <= DONE;
               end else begin
                  state_r <= CALC;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.quot     = quot_r;
   assign bus.rem      = rem_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_seq_divider4.sv
// Self-checking bench for seq_divider4: directed cases, handshake corner cases,
// randomized operands and an exhaustive sweep against an arithmetic reference.
module tb_seq_divider4;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   seq_divider4_if #(.WIDTH(4)) bus ();

   seq_divider4 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer divide, zero divisor gives all-ones/0/flag, result
   // visible after edge E0+8 (nonzero) or right after E0 (zero).
   task automatic do_op(input logic [7:0] p, input logic [3:0] d);
      int         lat;
      int         el;
      logic [7:0] eq;
      logic [3:0] er;
      logic       ez;
      if (d == 4'd0) begin
         eq = 8'hFF; er = 4'd0; ez = 1'b1; el = 0;
      end else begin
         eq = p / d; er = 4'(p % d); ez = 1'b0; el = 8;
      end
      @(negedge clk);
      bus.start = 1'b1; bus.prod = p; bus.y = d;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.prod = 8'($urandom); bus.y = 4'($urandom);
      check_val("busy_after_accept", int'(bus.busy), 1);
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_val("done_seen", int'(bus.done), 1);
      check_val("latency", lat, el);
      check_val("quot", int'(bus.quot), int'(eq));
      check_val("rem", int'(bus.rem), int'(er));
      check_val("div_zero", int'(bus.div_zero), int'(ez));
      check_val("busy_in_done", int'(bus.busy), 1);
      if (d != 4'd0) begin
         check_val("identity", int'(bus.quot) * int'(d) + int'(bus.rem), int'(p));
         check_val("rem_lt_y", int'(bus.rem < d), 1);
      end
      @(negedge clk);
      check_val("done_one_cycle", int'(bus.done), 0);
      check_val("busy_after_done", int'(bus.busy), 0);
      check_val("quot_hold", int'(bus.quot), int'(eq));
   endtask

   // 200/7 with ignored start pulses in CALC (k=3) and in the DONE cycle (k=8).
   task automatic busy_ignore_test;
      int n_done;
      n_done = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.prod = 8'd200; bus.y = 4'd7;
      @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         bus.start = (k == 3 || k == 8);
         bus.prod  = 8'd143;
         bus.y     = 4'd11;
         if (bus.done) begin
            n_done++;
            check_val("ign_done_edge", k, 8);
            check_val("ign_quot", int'(bus.quot), 28);
            check_val("ign_rem", int'(bus.rem), 4);
            check_val("ign_busy_done", int'(bus.busy), 1);
         end
         if (k == 9 || k == 10) check_val("ign_idle_busy", int'(bus.busy), 0);
      end
      bus.start = 1'b0;
      check_val("ign_done_count", n_done, 1);
   endtask

   // Asynchronous reset in the middle of an operation.
   task automatic reset_abort_test;
      int n_done;
      n_done = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.prod = 8'd143; bus.y = 4'd11;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("rst_quot", int'(bus.quot), 0);
      check_val("rst_rem", int'(bus.rem), 0);
      check_val("rst_busy", int'(bus.busy), 0);
      check_val("rst_done", int'(bus.done), 0);
      check_val("rst_dz", int'(bus.div_zero), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check_val("rst_no_done", n_done, 0);
      check_val("rst_idle_busy", int'(bus.busy), 0);
      do_op(8'd200, 4'd7);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.prod = 8'd0; bus.y = 4'd0;
      #3;
      check_val("reset_quot", int'(bus.quot), 0);
      check_val("reset_rem", int'(bus.rem), 0);
      check_val("reset_busy", int'(bus.busy), 0);
      check_val("reset_done", int'(bus.done), 0);
      check_val("reset_dz", int'(bus.div_zero), 0);
      @(negedge clk);
      rst = 1'b0;

      do_op(8'd143, 4'd11);
      do_op(8'd225, 4'd15);
      do_op(8'd200, 4'd7);
      do_op(8'd255, 4'd1);
      do_op(8'd0,   4'd9);
      do_op(8'd5,   4'd9);
      do_op(8'd77,  4'd0);
      do_op(8'd60,  4'd6);

      busy_ignore_test();
      reset_abort_test();

      for (int i = 0; i < 300; i++) begin
         do_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      end

      for (int p = 0; p < 256; p++) begin
         for (int d = 1; d < 16; d++) begin
            do_op(8'(p), 4'(d));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
